// File: rtl/axi4_lite_pkg.sv
// Shared AXI4-Lite constants and the initiator FSM state encoding.
package axi4_lite_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  localparam logic [2:0] PROT_DEFAULT = 3'b000;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_WR_REQ  = 3'd1,
    ST_WR_RESP = 3'd2,
    ST_RD_REQ  = 3'd3,
    ST_RD_DATA = 3'd4,
    ST_RSP     = 3'd5
  } state_t;

endpackage

// File: rtl/axi4_lite_master.sv
// One-at-a-time command/response to AXI4-Lite initiator; all AXI outputs registered.
// Zero-wait slave: accept-to-rsp_valid is 4 cycles for both reads and writes.
module axi4_lite_master
  import axi4_lite_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int STRB_WIDTH = DATA_WIDTH / 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_write,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [DATA_WIDTH-1:0] cmd_wdata,
  input  logic [STRB_WIDTH-1:0] cmd_wstrb,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic                  rsp_write,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic [1:0]            rsp_resp,
  output logic [ADDR_WIDTH-1:0] m_awaddr,
  output logic [2:0]            m_awprot,
  output logic                  m_awvalid,
  input  logic                  m_awready,
  output logic [DATA_WIDTH-1:0] m_wdata,
  output logic [STRB_WIDTH-1:0] m_wstrb,
  output logic                  m_wvalid,
  input  logic                  m_wready,
  input  logic [1:0]            m_bresp,
  input  logic                  m_bvalid,
  output logic                  m_bready,
  output logic [ADDR_WIDTH-1:0] m_araddr,
  output logic [2:0]            m_arprot,
  output logic                  m_arvalid,
  input  logic                  m_arready,
  input  logic [DATA_WIDTH-1:0] m_rdata,
  input  logic [1:0]            m_rresp,
  input  logic                  m_rvalid,
  output logic                  m_rready
);

  state_t                r_state;
  state_t                w_next;
  logic                  w_accept;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [DATA_WIDTH-1:0] r_wdata;
  logic [STRB_WIDTH-1:0] r_wstrb;
  logic                  r_write;
  logic                  r_awvalid, r_wvalid, r_arvalid;
  logic                  r_aw_done, r_w_done, r_ar_done;
  logic                  r_bready, r_rready;
  logic                  r_rsp_valid;
  logic [DATA_WIDTH-1:0] r_rdata;
  logic [1:0]            r_resp;

  assign w_accept = (r_state == ST_IDLE) && cmd_valid;

  // Request states advance one cycle after the handshake, via the sticky done flags.
  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:    if (cmd_valid) w_next = cmd_write ? ST_WR_REQ : ST_RD_REQ;
      ST_WR_REQ:  if (r_aw_done && r_w_done) w_next = ST_WR_RESP;
      ST_WR_RESP: if (m_bvalid && r_bready) w_next = ST_RSP;
      ST_RD_REQ:  if (r_ar_done) w_next = ST_RD_DATA;
      ST_RD_DATA: if (m_rvalid && r_rready) w_next = ST_RSP;
      ST_RSP:     if (rsp_ready) w_next = ST_IDLE;
      default:    w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_wstrb     <= '0;
      r_write     <= 1'b0;
      r_awvalid   <= 1'b0;
      r_wvalid    <= 1'b0;
      r_arvalid   <= 1'b0;
      r_aw_done   <= 1'b0;
      r_w_done    <= 1'b0;
      r_ar_done   <= 1'b0;
      r_bready    <= 1'b0;
      r_rready    <= 1'b0;
      r_rsp_valid <= 1'b0;
      r_rdata     <= '0;
      r_resp      <= '0;
    end else begin
      r_state     <= w_next;
      r_bready    <= (w_next == ST_WR_RESP);
      r_rready    <= (w_next == ST_RD_DATA);
      r_rsp_valid <= (w_next == ST_RSP);
      if (w_accept) begin
        r_addr    <= cmd_addr;
        r_wdata   <= cmd_wdata;
        r_wstrb   <= cmd_wstrb;
        r_write   <= cmd_write;
        r_awvalid <= cmd_write;
        r_wvalid  <= cmd_write;
        r_arvalid <= !cmd_write;
        r_aw_done <= 1'b0;
        r_w_done  <= 1'b0;
        r_ar_done <= 1'b0;
      end else begin
        if (r_awvalid && m_awready) begin
          r_awvalid <= 1'b0;
          r_aw_done <= 1'b1;
        end
        if (r_wvalid && m_wready) begin
          r_wvalid <= 1'b0;
          r_w_done <= 1'b1;
        end
        if (r_arvalid && m_arready) begin
          r_arvalid <= 1'b0;
          r_ar_done <= 1'b1;
        end
      end
      if ((r_state == ST_WR_RESP) && m_bvalid && r_bready) begin
        r_resp  <= m_bresp;
        r_rdata <= '0;
      end
      if ((r_state == ST_RD_DATA) && m_rvalid && r_rready) begin
        r_resp  <= m_rresp;
        r_rdata <= m_rdata;
      end
    end
  end

  assign cmd_ready = (r_state == ST_IDLE);
  assign rsp_valid = r_rsp_valid;
  assign rsp_write = r_write;
  assign rsp_rdata = r_rdata;
  assign rsp_resp  = r_resp;
  assign m_awaddr  = r_addr;
  assign m_awprot  = PROT_DEFAULT;
  assign m_awvalid = r_awvalid;
  assign m_wdata   = r_wdata;
  assign m_wstrb   = r_wstrb;
  assign m_wvalid  = r_wvalid;
  assign m_bready  = r_bready;
  assign m_araddr  = r_addr;
  assign m_arprot  = PROT_DEFAULT;
  assign m_arvalid = r_arvalid;
  assign m_rready  = r_rready;

endmodule

// File: doc/axi4_lite_master.md
Name: axi4_lite_master

Overview:
AXI4-Lite initiator that converts a simple one-at-a-time command/response interface into AXI4-Lite read and write transactions. It is the bus master that drives the register-file slave path: host-side logic or a test sequencer issues commands, and the block sequences the AW/W/B or AR/R channels. At most one transaction is outstanding. All AXI outputs are registered.

Parameters:
ADDR_WIDTH, 32, AXI address width in bits
DATA_WIDTH, 32, AXI data width in bits; must be 32 or 64
STRB_WIDTH, DATA_WIDTH/8, write-strobe width (derived; do not override)

Ports:
clk  in  1  clock; all logic on rising edge
rst_n  in  1  asynchronous active-low reset
cmd_valid  in  1  command request
cmd_ready  out  1  block idle, command accepted this cycle if cmd_valid
cmd_write  in  1  1 = write, 0 = read
cmd_addr  in  ADDR_WIDTH  byte address, passed through unmodified
cmd_wdata  in  DATA_WIDTH  write data (ignored for reads)
cmd_wstrb  in  STRB_WIDTH  byte strobes (ignored for reads)
rsp_valid  out  1  response available
rsp_ready  in  1  response consumer ready
rsp_write  out  1  echo of cmd_write for this response
rsp_rdata  out  DATA_WIDTH  read data; 0 for writes
rsp_resp  out  2  BRESP/RRESP captured from the slave
m_awaddr  out  ADDR_WIDTH  AW address
m_awprot  out  3  tied to 3'b000
m_awvalid  out  1  AW valid
m_awready  in  1  AW ready
m_wdata  out  DATA_WIDTH  W data
m_wstrb  out  STRB_WIDTH  W strobes
m_wvalid  out  1  W valid
m_wready  in  1  W ready
m_bresp  in  2  B response
m_bvalid  in  1  B valid
m_bready  out  1  B ready
m_araddr  out  ADDR_WIDTH  AR address
m_arprot  out  3  tied to 3'b000
m_arvalid  out  1  AR valid
m_arready  in  1  AR ready
m_rdata  in  DATA_WIDTH  R data
m_rresp  in  2  R response
m_rvalid  in  1  R valid
m_rready  out  1  R ready

Behaviour:
- Reset values: state IDLE, cmd_ready=1; all of m_awvalid, m_wvalid, m_bready, m_arvalid, m_rready, rsp_valid = 0; all address, data and response registers = 0.
- FSM states:
  - IDLE: cmd_ready=1. On cmd_valid, capture addr/wdata/wstrb/write. Go to WR_REQ if cmd_write, else RD_REQ.
  - WR_REQ: m_awvalid and m_wvalid both rise 1 cycle after acceptance. Each channel drops independently on its own handshake (valid&ready). Sticky flags aw_done and w_done record completion. Enter WR_RESP in the cycle after both are done; this covers AW and W completing in the same cycle or in either order.
  - WR_RESP: m_bready=1. On m_bvalid, capture m_bresp into rsp_resp, set rsp_rdata=0, go to RSP.
  - RD_REQ: m_arvalid=1 until m_arready, then go to RD_DATA.
  - RD_DATA: m_rready=1. On m_rvalid, capture m_rdata and m_rresp, go to RSP.
  - RSP: rsp_valid=1, outputs stable. On rsp_ready, go to IDLE (rsp_valid=0 and cmd_ready=1 the next cycle).
- AXI rules:
  - Once a valid is asserted, it and its payload stay unchanged until the handshake completes.
  - No valid waits on the corresponding ready.
  - m_bready and m_rready are asserted only in their wait states.
- Latency with zero-wait slave: cmd accept to awvalid/arvalid is 1 cycle. Minimum accept-to-rsp_valid is 4 cycles for a read and 4 cycles for a write.
- rsp_resp is passed through verbatim; SLVERR/DECERR are not an error for the block and carry no retry.
- cmd_valid while busy: ignored; cmd_ready=0 outside IDLE.
- rsp_ready held low: stays in RSP indefinitely with no new commands accepted.
- Asynchronous reset mid-transaction: all valids drop immediately and the FSM returns to IDLE. The slave is required to be reset by the same rst_n.
- m_bvalid/m_rvalid seen outside their wait state: ignored; ready stays 0.

Decomposition:
- Shared package axi4_lite_pkg:
  - response constants RESP_OKAY=2'b00, RESP_EXOKAY=2'b01, RESP_SLVERR=2'b10, RESP_DECERR=2'b11
  - PROT_DEFAULT=3'b000
  - the state encoding for this FSM
- No sub-module; single FSM plus capture registers.

Test Plan:
- Write cmd addr=0x08, wdata=0xDEADBEEF, wstrb=0xF against a zero-wait register-file slave -> one AW and one W handshake with awaddr=0x08. rsp_valid with rsp_write=1, rsp_resp=00, rsp_rdata=0.
- Read addr=0x08 after the above -> araddr=0x08; rsp_rdata=0xDEADBEEF, rsp_resp=00.
- Write wdata=0x11223344, wstrb=0x5 to 0x0C (register previously 0xFFFFFFFF), then read 0x0C -> rsp_rdata=0xFF22FF44.
- Slave holds awready low 3 cycles while wready is immediate; repeat with the order swapped -> m_wvalid drops after 1 cycle, m_awvalid held with stable awaddr until awready, m_bready rises only after both are done, rsp_resp=00.
- rsp_ready held low 5 cycles with cmd_valid=1 -> rsp_valid and data stable, cmd_ready=0, no new AW/AR; new command accepted the cycle after the rsp_ready handshake.
- rst_n pulsed low while m_arvalid=1 -> m_arvalid=0 immediately; after release, cmd_ready=1 and rsp_valid=0; a subsequent read completes normally.
